// File: rtl/decoder_input_sampler.sv
// ---------------------------------------------------------------------------
// decoder_input_sampler
//
// Front-end for the decoder core. The raw io_in pins are asynchronous to clk,
// so they are first passed through a multi-flop synchronizer. The synchronized
// code is then debounced by a small FSM. A code that stays stable long enough,
// and differs from the last accepted code, is emitted once into a 2-entry
// FIFO. The FIFO head is presented to the decoder through a valid/ready
// handshake.
//
// Parameters:
//   WIDTH          width of the io_in code bus
//   SYNC_STAGES    synchronizer depth in flops (>= 2)
//   STABLE_CYCLES  settle cycles a candidate must survive before it is
//                  accepted (>= 1)
//
// Ports:
//   clk         single system clock
//   rst_n       asynchronous, active-low reset
//   io_in       raw pin code, asynchronous to clk
//   enable      1 = detection of new codes is active
//   code_out    head-of-queue code, registered
//   code_valid  code_out holds an unconsumed code
//   code_ready  decoder accepts code_out this cycle
//   overflow    sticky: a code was dropped because the queue was full
//   clr_ovf     synchronous clear for overflow (a same-cycle set wins)
//   busy        debounce FSM is not in WAIT
// ---------------------------------------------------------------------------
module decoder_input_sampler #(
  parameter int WIDTH         = 7,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] io_in,
  input  logic             enable,
  output logic [WIDTH-1:0] code_out,
  output logic             code_valid,
  input  logic             code_ready,
  output logic             overflow,
  input  logic             clr_ovf,
  output logic             busy
);

  // The counter has to hold values up to STABLE_CYCLES.
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SETTLE = 2'd1,
    EMIT   = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Synchronizer
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sampled;

  // Each io_in bit passes through SYNC_STAGES flops. Only the last stage is
  // treated as metastability-safe and used by any other logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= io_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sampled = sync_q[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Debounce FSM
  // -------------------------------------------------------------------------
  state_t           state;
  logic [WIDTH-1:0] candidate;
  logic [WIDTH-1:0] last_accepted;
  logic [CNT_W-1:0] cnt;

  // WAIT looks for a code that differs from the last accepted one. SETTLE
  // checks that the candidate survives for STABLE_CYCLES cycles. The count is
  // compared before it is incremented, so STABLE_CYCLES=1 leaves SETTLE on its
  // first cycle. A short excursion that falls back to the accepted code is
  // treated as a glitch. A move to a third code restarts the settle window.
  // EMIT lasts one cycle and updates last_accepted even when the queue drops
  // the code. This keeps a dropped code from being retried.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= WAIT;
      candidate     <= '0;
      last_accepted <= '0;
      cnt           <= '0;
    end else begin
      case (state)
        WAIT: begin
          if (enable && (sampled != last_accepted)) begin
            candidate <= sampled;
            cnt       <= CNT_ONE;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          if (!enable) begin
            state <= WAIT;
          end else if (sampled == candidate) begin
            if (cnt == CNT_TARGET) begin
              state <= EMIT;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end else if (sampled == last_accepted) begin
            state <= WAIT;
          end else begin
            candidate <= sampled;
            cnt       <= CNT_ONE;
          end
        end
        EMIT: begin
          last_accepted <= candidate;
          state         <= WAIT;
        end
        default: begin
          state <= WAIT;
        end
      endcase
    end
  end

  assign busy = (state != WAIT);

  // -------------------------------------------------------------------------
  // 2-entry output queue
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       count_q;
  logic             push;
  logic             pop;
  logic             drop;

  assign push       = (state == EMIT);
  assign code_valid = (count_q != 2'd0);
  assign pop        = code_valid & code_ready;
  // A push into a full queue succeeds when a pop frees a slot in the same cycle.
  assign drop       = push & ~pop & (count_q == 2'd2);

  // code_out is the head register itself, so it has no combinational path
  // from io_in. It is stable while the decoder stalls. After the last entry
  // is popped, the head register keeps that value, because a pop from a
  // single-entry queue only clears the count. tail_q holds the second entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_out <= '0;
      tail_q   <= '0;
      count_q  <= 2'd0;
      overflow <= 1'b0;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (count_q == 2'd2) begin
            code_out <= tail_q;
            tail_q   <= candidate;
          end else begin
            code_out <= candidate;
          end
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            code_out <= candidate;
            count_q  <= 2'd1;
          end else if (count_q == 2'd1) begin
            tail_q  <= candidate;
            count_q <= 2'd2;
          end
        end
        2'b01: begin
          if (count_q == 2'd2) begin
            code_out <= tail_q;
            count_q  <= 2'd1;
          end else begin
            count_q <= 2'd0;
          end
        end
        default: begin
        end
      endcase
      // A drop in the same cycle as clr_ovf keeps the flag set.
      overflow <= drop | (overflow & ~clr_ovf);
    end
  end

endmodule
